vga_timing_gen: RTL and testbench

Generates 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock: horizontal/vertical pixel counters, active-low sync pulses, the active-video flag and a start-of-frame strobe. It sits directly upstream of every pixel-drawing stage. Its `DrawX`, `DrawY` and `blank` outputs feed the background and sprite renderers, which register colour one cycle later. `hs`/`vs` go to the VGA connector through the same one-cycle pipeline stage as the colour outputs.

---
 rtl/vga_timing_gen.sv | 119 +++++++++++
 tb/tb_vga_timing_gen.sv | 138 +++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel/line counters, active-low syncs, active-video flag
// and start-of-frame strobe, all registered and aligned to the same clock edge.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Last count of each phase; the phase FSM steps when the counter sits on it.
  localparam logic [9:0] H_VIS_END   = 10'(H_VISIBLE - 1);
  localparam logic [9:0] H_FRONT_END = 10'(H_VISIBLE + H_FRONT - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_VIS_END   = 10'(V_VISIBLE - 1);
  localparam logic [9:0] V_FRONT_END = 10'(V_VISIBLE + V_FRONT - 1);
  localparam logic [9:0] V_SYNC_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);

  localparam logic [1:0] PH_VISIBLE = 2'd0;
  localparam logic [1:0] PH_FRONT   = 2'd1;
  localparam logic [1:0] PH_SYNC    = 2'd2;
  localparam logic [1:0] PH_BACK    = 2'd3;

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic [1:0] hph_q, hph_d;
  logic [1:0] vph_q, vph_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic       fs_q, fs_d;
  logic       h_wrap;
  logic       v_wrap;

  function automatic logic [1:0] next_phase(
    input logic [1:0] ph,
    input logic [9:0] cnt,
    input logic [9:0] vis_end,
    input logic [9:0] front_end,
    input logic [9:0] sync_end,
    input logic [9:0] last
  );
    logic [1:0] nxt;
    nxt = ph;
    case (ph)
      PH_VISIBLE: if (cnt == vis_end)   nxt = PH_FRONT;
      PH_FRONT:   if (cnt == front_end) nxt = PH_SYNC;
      PH_SYNC:    if (cnt == sync_end)  nxt = PH_BACK;
      PH_BACK:    if (cnt == last)      nxt = PH_VISIBLE;
      default:                          nxt = PH_VISIBLE;
    endcase
    return nxt;
  endfunction

  always_comb begin
    h_wrap = (hc_q == H_LAST);
    v_wrap = h_wrap && (vc_q == V_LAST);
    hc_d   = h_wrap ? 10'd0 : hc_q + 10'd1;
    vc_d   = vc_q;
    if (h_wrap) vc_d = v_wrap ? 10'd0 : vc_q + 10'd1;

    hph_d = next_phase(hph_q, hc_q, H_VIS_END, H_FRONT_END, H_SYNC_END, H_LAST);
    vph_d = vph_q;
    if (h_wrap) vph_d = next_phase(vph_q, vc_q, V_VIS_END, V_FRONT_END, V_SYNC_END, V_LAST);

    // Decoded from next-state phases so flags line up with the new counter values.
    hs_d    = (hph_d != PH_SYNC);
    vs_d    = (vph_d != PH_SYNC);
    blank_d = (hph_d == PH_VISIBLE) && (vph_d == PH_VISIBLE);
    fs_d    = v_wrap;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc_q    <= 10'd0;
      vc_q    <= 10'd0;
      hph_q   <= PH_VISIBLE;
      vph_q   <= PH_VISIBLE;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      hph_q   <= hph_d;
      vph_q   <= vph_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a shrunken-timing instance driven
// together, compared every cycle against a model computed from the clock count since reset.
module tb_vga_timing_gen;

  localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 6;
  localparam int SVV = 12, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SVT = SVV + SVF + SVS + SVB;

  logic       vga_clk = 1'b0;
  logic       reset;
  logic [9:0] d_x, d_y, s_x, s_y;
  logic       d_hs, d_vs, d_blank, d_fs;
  logic       s_hs, s_vs, s_blank, s_fs;

  int nchecks = 0;
  int nerrors = 0;
  int t = 0;
  bit have_frame = 0;
  bit prev_hs = 1;
  int bcnt = 0, hcnt = 0, per = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen dut_d (
    .vga_clk(vga_clk), .reset(reset), .DrawX(d_x), .DrawY(d_y),
    .hs(d_hs), .vs(d_vs), .blank(d_blank), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) dut_s (
    .vga_clk(vga_clk), .reset(reset), .DrawX(s_x), .DrawY(s_y),
    .hs(s_hs), .vs(s_vs), .blank(s_blank), .frame_start(s_fs)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
    end
  endtask

  // Raster position and flags after tc clocks since reset release, from the timing rules.
  task automatic model(input int tc, input int hv, input int hf, input int hsy, input int hb,
                       input int vv, input int vf, input int vsy, input int vb,
                       output int x, output int y, output bit ehs, output bit evs,
                       output bit ebl, output bit efs);
    int ht, vt;
    ht  = hv + hf + hsy + hb;
    vt  = vv + vf + vsy + vb;
    x   = tc % ht;
    y   = (tc / ht) % vt;
    ehs = !(x >= hv + hf && x < hv + hf + hsy);
    evs = !(y >= vv + vf && y < vv + vf + vsy);
    ebl = (x < hv) && (y < vv);
    efs = (tc > 0) && (tc % (ht * vt) == 0);
  endtask

  task automatic check_all();
    int x, y;
    bit ehs, evs, ebl, efs;
    model(t, 640, 16, 96, 48, 480, 10, 2, 33, x, y, ehs, evs, ebl, efs);
    chk("D.DrawX", 32'(d_x), 32'(x));
    chk("D.DrawY", 32'(d_y), 32'(y));
    chk("D.hs", 32'(d_hs), 32'(ehs));
    chk("D.vs", 32'(d_vs), 32'(evs));
    chk("D.blank", 32'(d_blank), 32'(ebl));
    chk("D.frame_start", 32'(d_fs), 32'(efs));
    model(t, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, x, y, ehs, evs, ebl, efs);
    chk("S.DrawX", 32'(s_x), 32'(x));
    chk("S.DrawY", 32'(s_y), 32'(y));
    chk("S.hs", 32'(s_hs), 32'(ehs));
    chk("S.vs", 32'(s_vs), 32'(evs));
    chk("S.blank", 32'(s_blank), 32'(ebl));
    chk("S.frame_start", 32'(s_fs), 32'(efs));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge vga_clk);
      t++;
      @(negedge vga_clk);
      check_all();
      if (s_fs) begin
        if (have_frame) begin
          chk("S.frame_period", 32'(per), 32'(SHT * SVT));
          chk("S.blank_clocks", 32'(bcnt), 32'(SHV * SVV));
          chk("S.hs_pulses", 32'(hcnt), 32'(SVT));
        end
        have_frame = 1;
        bcnt = 0;
        hcnt = 0;
        per  = 0;
      end
      if (s_blank) bcnt++;
      if (prev_hs && !s_hs) hcnt++;
      prev_hs = s_hs;
      per++;
    end
  endtask

  task automatic hold_and_release();
    t = 0;
    have_frame = 0;
    prev_hs = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge vga_clk);
      check_all();
    end
    reset = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1;
    hold_and_release();
    run(9000);
    for (int k = 0; k < 6; k++) begin
      run($urandom_range(1, 1500));
      @(posedge vga_clk);
      t++;
      #($urandom_range(1, 8));
      reset = 1'b1;
      #1;
      t = 0;
      check_all();
      hold_and_release();
    end
    run(1300);
    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
